// File: rtl/sig_gen_pkg.sv
// Shared types and constants for the waveform index sequencer.
package sig_gen_pkg;

    localparam int unsigned SAMPLES_PER_PERIOD = 200;
    localparam int unsigned SEG_LEN            = 50;
    localparam int unsigned IDX_W              = 8;
    localparam int unsigned PHASE_FRAC_W       = 8;

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_SEG     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Encoding 3 is reserved and behaves as full-table looping.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SEG;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_LOOP;
        endcase
    endfunction

endpackage

// File: rtl/sample_tick_div.sv
// Programmable sample-rate divider: tick once every div+1 clocks while running.
module sample_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= keeps the period bounded if div shrinks below the running count.
    assign tick = run && (cnt >= div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/wave_index_gen.sv
// Sample-index sequencer for the 200-entry waveform LUT: divider, 8.8 phase accumulator, mode FSM.
module wave_index_gen
    import sig_gen_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_PERIOD = sig_gen_pkg::SAMPLES_PER_PERIOD,
    parameter int unsigned SEG_LEN            = sig_gen_pkg::SEG_LEN,
    parameter int unsigned DIV_W              = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sync_restart,
    input  logic [1:0]       mode,
    input  logic [1:0]       seg_sel,
    input  logic [DIV_W-1:0] div,
    input  logic [15:0]      step,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam int unsigned PH_W = IDX_W + PHASE_FRAC_W;

    state_e          state;
    mode_e           mode_q;
    logic [1:0]      seg_q;
    logic [15:0]     step_q;
    logic [PH_W-1:0] phase;
    logic            wrap_pending;

    logic             tick;
    logic             div_clear;
    logic [IDX_W-1:0] span;
    logic [IDX_W-1:0] base;
    logic [PH_W-1:0]  step_eff;
    logic [PH_W:0]    acc;
    logic [PH_W:0]    span_fx;
    logic             adv_wrap;
    logic [PH_W-1:0]  phase_next;

    assign div_clear = (state != RUN) || sync_restart;

    sample_tick_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clear(div_clear),
        .run  (state == RUN),
        .div  (div),
        .tick (tick)
    );

    always_comb begin
        span       = (mode_q == MODE_SEG) ? IDX_W'(SEG_LEN) : IDX_W'(SAMPLES_PER_PERIOD);
        base       = (mode_q == MODE_SEG) ? IDX_W'(seg_q) * IDX_W'(SEG_LEN) : '0;
        step_eff   = (step_q[15:8] >= span) ? {span - IDX_W'(1), 8'hFF} : step_q;
        acc        = {1'b0, phase} + {1'b0, step_eff};
        span_fx    = {1'b0, span, 8'h00};
        adv_wrap   = (acc >= span_fx);
        phase_next = adv_wrap ? PH_W'(acc - span_fx) : acc[PH_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode_q       <= MODE_LOOP;
            seg_q        <= '0;
            step_q       <= '0;
            phase        <= '0;
            wrap_pending <= 1'b0;
            index        <= '0;
            index_valid  <= 1'b0;
            wrap         <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            wrap        <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        phase        <= '0;
                        wrap_pending <= 1'b0;
                        mode_q       <= decode_mode(mode);
                        seg_q        <= seg_sel;
                        step_q       <= step;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sync_restart) begin
                        phase        <= '0;
                        wrap_pending <= 1'b0;
                        mode_q       <= decode_mode(mode);
                        seg_q        <= seg_sel;
                        step_q       <= step;
                    end else if (tick) begin
                        // One-shot ends on the tick that would emit the wrapped sample.
                        if (mode_q == MODE_ONESHOT && wrap_pending) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index        <= base + phase[PH_W-1:PHASE_FRAC_W];
                            index_valid  <= 1'b1;
                            wrap         <= wrap_pending;
                            phase        <= phase_next;
                            wrap_pending <= adv_wrap;
                            if (adv_wrap && mode_q != MODE_ONESHOT) begin
                                mode_q <= decode_mode(mode);
                                seg_q  <= seg_sel;
                                step_q <= step;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_index_gen.sv
// Scoreboard bench for wave_index_gen: directed runs per mode, restart, reset.
module tb_wave_index_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sync_restart = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  seg_sel = 2'd0;
    logic [15:0] div = 16'd0;
    logic [15:0] step = 16'd0;
    logic [7:0]  index;
    logic        index_valid;
    logic        wrap;
    logic        done;
    logic        busy;

    wave_index_gen #(
        .SAMPLES_PER_PERIOD(200),
        .SEG_LEN           (50),
        .DIV_W             (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sync_restart(sync_restart),
        .mode        (mode),
        .seg_sel     (seg_sel),
        .div         (div),
        .step        (step),
        .index       (index),
        .index_valid (index_valid),
        .wrap        (wrap),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] idx;
        logic       w;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   exp_gap = 0;
    bit   have_prev = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic push(input int idx, input bit w);
        exp_t e;
        e.idx = 8'(idx);
        e.w   = w;
        q.push_back(e);
    endtask

    // Monitor: every presented sample is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (index_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got index=%0d wrap=%0b, required no sample", index, wrap);
            end else begin
                mon_e = q.pop_front();
                chk("index", 32'(index), 32'(mon_e.idx));
                chk("wrap", 32'(wrap), 32'(mon_e.w));
            end
            if (have_prev && exp_gap != 0) chk("sample_gap", 32'(cyc - last_cyc), 32'(exp_gap));
            last_cyc  = cyc;
            have_prev = 1'b1;
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [1:0] s, input logic [15:0] d, input logic [15:0] st);
        mode    = m;
        seg_sel = s;
        div     = d;
        step    = st;
        enable  = 1'b1;
        @(negedge clk);
        chk("busy_rise", 32'(busy), 32'd1);
        last_cyc  = cyc;
        have_prev = 1'b1;
        exp_gap   = int'(d) + 1;
    endtask

    task automatic drain(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d samples outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic stop_run();
        enable = 1'b0;
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_after_stop", 32'(index_valid), 32'd0);
        have_prev = 1'b0;
        exp_gap   = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_index"}, 32'(index), 32'd0);
        chk({tag, "_valid"}, 32'(index_valid), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit found;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // Mode 0, unit step: 0..199 then 0 with wrap.
        start_run(2'd0, 2'd0, 16'd0, 16'h0100);
        for (int i = 0; i < 200; i++) push(i, 1'b0);
        push(0, 1'b1);
        push(1, 1'b0);
        drain(400);
        stop_run();

        // Mode 0, step 1.5: 0,1,3,4,...,198,199 then 1 with wrap.
        start_run(2'd0, 2'd0, 16'd0, 16'h0180);
        for (int k = 0; k < 134; k++) push((k * 3) / 2, 1'b0);
        push(1, 1'b1);
        push(2, 1'b0);
        drain(300);
        stop_run();

        // Mode 1, segment 2, div 3, step 3: 100..148 then 101 with wrap.
        start_run(2'd1, 2'd2, 16'd3, 16'h0300);
        for (int k = 0; k < 17; k++) push(100 + 3 * k, 1'b0);
        push(101, 1'b1);
        push(104, 1'b0);
        drain(200);
        stop_run();

        // Mode 2, step 10: 0..190 then done, index held.
        start_run(2'd2, 2'd0, 16'd0, 16'h0A00);
        for (int k = 0; k < 20; k++) push(10 * k, 1'b0);
        drain(100);
        found = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(found), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_index_hold", 32'(index), 32'd190);
        chk("done_no_sample", 32'(index_valid), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_hold_index", 32'(index), 32'd190);
        #1;
        stop_run();

        // Mode 1, segment 3, oversized step clamps to 49.FF.
        start_run(2'd1, 2'd3, 16'd0, 16'h4000);
        push(150, 1'b0);
        push(199, 1'b0);
        push(199, 1'b1);
        push(199, 1'b1);
        drain(20);
        stop_run();

        // Restart at index 57, then reset mid-run.
        start_run(2'd0, 2'd0, 16'd1, 16'h0100);
        for (int i = 0; i <= 57; i++) push(i, 1'b0);
        drain(200);
        sync_restart = 1'b1;
        @(posedge clk);
        #1;
        sync_restart = 1'b0;
        last_cyc     = cyc;
        exp_gap      = 2;
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b0);
        @(negedge clk);
        chk("restart_gap0", 32'(index_valid), 32'd0);
        @(negedge clk);
        chk("restart_gap1", 32'(index_valid), 32'd0);
        #1;
        drain(20);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        have_prev = 1'b0;
        exp_gap   = 0;
        enable    = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
